// File: rtl/divider_pkg.sv
// divider_pkg: shared state encoding, default width and counter sizing for the divider controller
package divider_pkg;

    localparam int C_NUM_BITS_DEF = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/divider_seq_if.sv
// divider_seq_if: request/result handshake and datapath control bundle around the divider controller
interface divider_seq_if #(
    parameter int C_NUM_BITS = divider_pkg::C_NUM_BITS_DEF
);
    logic                  IN_VALID;
    logic                  IN_READY;
    logic [C_NUM_BITS-1:0] B;
    logic                  TRIAL_NEG;
    logic                  DP_EN;
    logic                  LD;
    logic                  SH;
    logic                  RESTORE;
    logic                  Q_BIT;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic                  DZ;
    logic                  BUSY;

    // requester/datapath side
    modport master (
        output IN_VALID, B, TRIAL_NEG, OUT_READY,
        input  IN_READY, DP_EN, LD, SH, RESTORE, Q_BIT, OUT_VALID, DZ, BUSY
    );

    // controller side
    modport slave (
        input  IN_VALID, B, TRIAL_NEG, OUT_READY,
        output IN_READY, DP_EN, LD, SH, RESTORE, Q_BIT, OUT_VALID, DZ, BUSY
    );
endinterface

// File: rtl/divider_seq.sv
// divider_seq: sequencing controller for a restoring-division datapath
module divider_seq
    import divider_pkg::*;
#(
    parameter int C_NUM_BITS = C_NUM_BITS_DEF,
    parameter int C_CNT_BITS = cnt_width(C_NUM_BITS)
) (
    input  logic          CK,
    input  logic          RN,
    divider_seq_if.slave  bus
);

    localparam logic [C_CNT_BITS-1:0] C_LAST = C_CNT_BITS'(C_NUM_BITS - 1);

    state_t                state_q;
    logic [C_CNT_BITS-1:0] cnt_q;
    logic                  dz_q;
    logic                  in_ready_q;
    logic                  dp_en_q;
    logic                  ld_q;
    logic                  sh_q;
    logic                  out_valid_q;
    logic                  busy_q;

    // FSM with every clock-gate-facing output held in a flop so it cannot glitch
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            dp_en_q     <= 1'b0;
            ld_q        <= 1'b0;
            sh_q        <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.IN_VALID) begin
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    if (bus.B == '0) begin
                        state_q     <= DONE;
                        dz_q        <= 1'b1;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q <= LOAD;
                        dz_q    <= 1'b0;
                        dp_en_q <= 1'b1;
                        ld_q    <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q <= ITER;
                    cnt_q   <= '0;
                    ld_q    <= 1'b0;
                    sh_q    <= 1'b1;
                end
                ITER: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        state_q     <= DONE;
                        dp_en_q     <= 1'b0;
                        sh_q        <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: if (bus.OUT_READY) begin
                    state_q     <= IDLE;
                    dz_q        <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.DP_EN     = dp_en_q;
    assign bus.LD        = ld_q;
    assign bus.SH        = sh_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.DZ        = dz_q;
    assign bus.BUSY      = busy_q;
    // restore/quotient decision comes straight from this cycle's trial sign
    assign bus.RESTORE   = sh_q & bus.TRIAL_NEG;
    assign bus.Q_BIT     = sh_q & ~bus.TRIAL_NEG;

endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: directed checks of the divider controller driving a behavioural restoring datapath
module tb_divider_seq;

    localparam int N = 24;

    logic         clk = 1'b0;
    logic         rn  = 1'b0;
    logic [N-1:0] A   = '0;
    logic [N-1:0] rem;
    logic [N-1:0] quo;
    logic [N:0]   shifted;
    logic [N:0]   diff;
    int           n_checks = 0;
    int           n_fail   = 0;
    int           sh_cnt = 0, ld_cnt = 0, rs_cnt = 0, en_cnt = 0, ov_cnt = 0, clash_cnt = 0;

    divider_seq_if #(.C_NUM_BITS(N)) bus ();

    divider_seq #(.C_NUM_BITS(N)) dut (
        .CK  (clk),
        .RN  (rn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // behavioural restoring datapath
    assign shifted       = {rem, quo[N-1]};
    assign diff          = shifted - {1'b0, bus.B};
    assign bus.TRIAL_NEG = shifted < {1'b0, bus.B};

    always @(posedge clk) begin
        if (bus.DP_EN === 1'b1) begin
            if (bus.LD === 1'b1) begin
                quo <= A;
                rem <= '0;
            end else if (bus.SH === 1'b1) begin
                rem <= bus.RESTORE ? shifted[N-1:0] : diff[N-1:0];
                quo <= {quo[N-2:0], bus.Q_BIT};
            end
        end
    end

    // per-cycle activity counters, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.SH === 1'b1) sh_cnt++;
        if (bus.LD === 1'b1) ld_cnt++;
        if (bus.RESTORE === 1'b1) rs_cnt++;
        if (bus.DP_EN === 1'b1) en_cnt++;
        if (bus.OUT_VALID === 1'b1) ov_cnt++;
        if ((bus.LD & bus.SH) === 1'b1 || ((bus.LD | bus.SH) & ~bus.DP_EN) === 1'b1) clash_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                       input int hold, input logic [N-1:0] eq, input logic [N-1:0] er,
                       input bit edz, input int elat, input int ers);
        int lat, s_sh, s_ld, s_rs, s_en;
        @(negedge clk);
        A             = a;
        bus.B         = b;
        bus.IN_VALID  = 1'b1;
        bus.OUT_READY = (hold == 0);
        chk({tag, "_in_ready"}, 32'(bus.IN_READY), 1);
        s_sh = sh_cnt; s_ld = ld_cnt; s_rs = rs_cnt; s_en = en_cnt;
        @(negedge clk);
        if (hold == 0) bus.IN_VALID = 1'b0;
        lat = 1;
        while (bus.OUT_VALID !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_dz"}, 32'(bus.DZ), 32'(edz));
        if (!edz) begin
            chk({tag, "_quo"}, 32'(quo), 32'(eq));
            chk({tag, "_rem"}, 32'(rem), 32'(er));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(bus.OUT_VALID), 1);
            chk({tag, "_hold_in_ready"}, 32'(bus.IN_READY), 0);
            chk({tag, "_hold_dz"}, 32'(bus.DZ), 32'(edz));
        end
        bus.OUT_READY = 1'b1;
        @(negedge clk);
        chk({tag, "_valid_drop"}, 32'(bus.OUT_VALID), 0);
        chk({tag, "_ready_back"}, 32'(bus.IN_READY), 1);
        chk({tag, "_busy_clear"}, 32'(bus.BUSY), 0);
        bus.IN_VALID = 1'b0;
        chk({tag, "_sh_pulses"}, sh_cnt - s_sh, edz ? 0 : N);
        chk({tag, "_ld_pulses"}, ld_cnt - s_ld, edz ? 0 : 1);
        chk({tag, "_dp_en_cycles"}, en_cnt - s_en, edz ? 0 : N + 1);
        if (ers >= 0) chk({tag, "_restores"}, rs_cnt - s_rs, ers);
    endtask

    initial begin
        int s_ov;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        bus.B         = '0;
        #12;
        chk("rst_in_ready", 32'(bus.IN_READY), 1);
        chk("rst_outs", {bus.DP_EN, bus.LD, bus.SH, bus.RESTORE, bus.Q_BIT, bus.OUT_VALID, bus.DZ, bus.BUSY}, 0);
        @(negedge clk);
        rn = 1'b1;

        // abandon a division mid-iteration
        @(negedge clk);
        A = 24'd100; bus.B = 24'd7; bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b1;
        @(negedge clk);
        bus.IN_VALID = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy", 32'(bus.BUSY), 1);
        chk("mid_sh", 32'(bus.SH), 1);
        rn = 1'b0;
        #1;
        chk("arst_in_ready", 32'(bus.IN_READY), 1);
        chk("arst_busy", 32'(bus.BUSY), 0);
        chk("arst_dp", {bus.DP_EN, bus.SH, bus.LD, bus.OUT_VALID}, 0);
        s_ov = ov_cnt;
        @(negedge clk);
        rn = 1'b1;
        repeat (30) @(negedge clk);
        chk("arst_no_valid", ov_cnt - s_ov, 0);

        run("d100_7", 24'd100, 24'd7, 0, 24'd14, 24'd2, 1'b0, N + 2, -1);
        run("dffffff_1", 24'hFFFFFF, 24'd1, 0, 24'hFFFFFF, 24'd0, 1'b0, N + 2, 0);
        run("d5_0", 24'd5, 24'd0, 0, 24'd0, 24'd0, 1'b1, 1, 0);
        run("d3_10_hold", 24'd3, 24'd10, 5, 24'd0, 24'd3, 1'b0, N + 2, -1);
        run("d20_3", 24'd20, 24'd3, 0, 24'd6, 24'd2, 1'b0, N + 2, -1);
        run("d0_9", 24'd0, 24'd9, 2, 24'd0, 24'd0, 1'b0, N + 2, N);

        chk("ld_sh_exclusive", clash_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
- Sequencing controller for the restoring-division datapath: remainder and quotient shift registers, trial subtractor and clock-gated register bank.
- Accepts one divide request through a valid/ready handshake, then drives the datapath load, shift and restore controls for C_NUM_BITS iteration cycles.
- Flags divide-by-zero and holds the result handshake until the consumer accepts it.
- Sits between the requesting core and the datapath. All datapath register writes are qualified by this block's control outputs.

Parameters:
- C_NUM_BITS, 24: operand, quotient and remainder width. Must be ≥ 2.
- C_CNT_BITS, $clog2(C_NUM_BITS): width of the iteration counter.

Ports:
- CK  in  1  clock.
- RN  in  1  asynchronous active-low reset.
- IN_VALID  in  1  requester has operands on the datapath A/B buses.
- IN_READY  out  1  controller can accept a request.
- B  in  C_NUM_BITS  divisor, used only for the zero check at acceptance.
- TRIAL_NEG  in  1  datapath: (2*rem + quo MSB) − B is negative, combinational in the current cycle.
- DP_EN  out  1  datapath clock-gate enable (drives the CLKGATE E pin).
- LD  out  1  load A into the quotient register and clear the remainder register.
- SH  out  1  shift {rem,quo} left one step and write the trial/restored remainder.
- RESTORE  out  1  write the restored remainder (2*rem + quo MSB) instead of the trial difference.
- Q_BIT  out  1  quotient bit inserted into the quotient LSB on SH.
- OUT_VALID  out  1  quotient/remainder valid on the datapath outputs.
- OUT_READY  in  1  consumer accepts the result.
- DZ  out  1  divide-by-zero flag, qualified by OUT_VALID.
- BUSY  out  1  a request is in progress (LOAD, ITER or DONE state).

Behaviour:
- Reset (RN low, asynchronous): state=IDLE, cnt=0, dz_r=0. All outputs are 0 except IN_READY=1.
  - Reset mid-operation abandons the division.
  - No OUT_VALID is produced for the abandoned request.
- States: IDLE, LOAD, ITER, DONE.
- IDLE:
  - IN_READY=1, DP_EN=0.
  - Accept when IN_VALID & IN_READY.
  - If B==0: go straight to DONE with dz_r=1, no LOAD/ITER. The datapath is not clocked.
  - Else go to LOAD with dz_r=0.
- LOAD (1 cycle): DP_EN=1, LD=1, cnt←0, next state ITER.
- ITER (exactly C_NUM_BITS cycles):
  - DP_EN=1, SH=1.
  - RESTORE=TRIAL_NEG and Q_BIT=~TRIAL_NEG, both combinational from TRIAL_NEG.
  - cnt increments each cycle.
  - When cnt==C_NUM_BITS−1, next state is DONE.
- DONE:
  - OUT_VALID=1, DP_EN=0, so the result registers hold. DZ=dz_r.
  - On OUT_READY, go to IDLE. OUT_VALID drops the next cycle.
- Latency:
  - Accept edge to OUT_VALID high is C_NUM_BITS+2 cycles (26 cycles at default).
  - Divide-by-zero: OUT_VALID is high 1 cycle after accept.
- IN_READY is 0 in LOAD, ITER and DONE. A new request is accepted no earlier than the cycle after the DONE handshake (no back-to-back overlap).
- OUT_VALID, once high, stays high and DZ stays stable until OUT_READY is sampled high.
- IN_VALID deasserting during LOAD or ITER has no effect; the operands must stay stable on A/B until OUT_VALID.
- On divide-by-zero the datapath outputs are don't-care; DZ=1 is the only defined result.
- LD, SH and RESTORE are never high together. LD/SH are high only with DP_EN=1.
- All outputs except RESTORE/Q_BIT are decoded from registered state only, so they are glitch-free for the clock gate.

Decomposition:
- Shared package divider_pkg:
  - state enum typedef (IDLE, LOAD, ITER, DONE);
  - C_NUM_BITS default;
  - counter width function.
- No sub-module needed. The iteration counter stays inline; the remainder and quotient registers live in the datapath.

Test Plan:
- Reset mid-ITER (cycle 10): RN pulse low → IN_READY=1, BUSY=0, no OUT_VALID. A fresh 100/7 request afterwards completes correctly.
- With the behavioural datapath model, A=100, B=7, OUT_READY=1 → OUT_VALID at accept+26, quotient 14, remainder 2, DZ=0, exactly 24 SH pulses, one LD.
- A=0xFFFFFF, B=1 → quotient 0xFFFFFF, remainder 0, RESTORE never asserted.
- A=5, B=0 → OUT_VALID one cycle after accept, DZ=1, LD/SH never asserted, DP_EN stays 0.
- A=3, B=10 with OUT_READY held low 5 cycles:
  - OUT_VALID holds;
  - IN_READY=0 while IN_VALID is asserted;
  - quotient 0, remainder 3 after release.
  - The next request is accepted only the cycle after the handshake.
